// File: rtl/cfg_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit config write bus between NUM_REQ masters,
// with burst locking, a registered single-cycle write strobe and an inter-write gap.
module cfg_bus_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter logic [7:0]  IRQ_CFG_BASE = 8'hC0,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned LOCK_MAX     = 16
) (
  input  logic                 cfg_clk,
  input  logic                 cfg_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 cfg_we,
  output logic [7:0]           cfg_addr,
  output logic [7:0]           cfg_wdata,
  output logic                 cfg_irq_sel,
  output logic                 busy,
  output logic [15:0]          wr_count
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [1:0] {StIdle, StOwn, StWrite, StGap} state_e;

  state_e             state_q, state_d;
  idx_t               owner_q, owner_d;
  idx_t               rr_ptr_q, rr_ptr_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic               last_q, last_d;
  logic [2:0]         gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               we_q, we_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               irq_q, irq_d;
  logic [15:0]        wr_count_q, wr_count_d;

  logic               win_found;
  idx_t               win_idx;
  int unsigned        cand;
  logic               own_valid, own_last;
  logic [7:0]         own_addr, own_wdata;
  logic               release_now;

  // Search upward from rr_ptr+1 with wrap; the previous owner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx_t'(cand)]) begin
        win_found = 1'b1;
        win_idx   = idx_t'(cand);
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == idx_t'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_addr  = req_addr[8*i +: 8];
        own_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  assign release_now = last_q || (beat_cnt_q == 8'(LOCK_MAX));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    gap_cnt_d  = gap_cnt_q;
    grant_d    = grant_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    irq_d      = irq_q;
    wr_count_d = wr_count_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d    = StOwn;
          owner_d    = win_idx;
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          beat_cnt_d = '0;
        end
      end
      StOwn: begin
        if (own_valid) begin
          addr_d     = own_addr;
          wdata_d    = own_wdata;
          irq_d      = (own_addr >= IRQ_CFG_BASE);
          last_d     = own_last;
          beat_cnt_d = beat_cnt_q + 8'd1;
          state_d    = StWrite;
          we_d       = 1'b1;
          if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
        end else begin
          state_d  = StIdle;
          rr_ptr_d = owner_q;
          grant_d  = '0;
        end
      end
      StWrite: begin
        if (GAP_CYCLES > 0) begin
          state_d   = StGap;
          gap_cnt_d = '0;
        end else if (release_now) begin
          state_d  = StIdle;
          rr_ptr_d = owner_q;
          grant_d  = '0;
        end else begin
          state_d = StOwn;
        end
      end
      StGap: begin
        if (gap_cnt_q == 3'(GAP_CYCLES - 1)) begin
          if (release_now) begin
            state_d  = StIdle;
            rr_ptr_d = owner_q;
            grant_d  = '0;
          end else begin
            state_d = StOwn;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge cfg_clk) begin
    if (cfg_rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= idx_t'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      last_q     <= 1'b0;
      gap_cnt_q  <= '0;
      grant_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      irq_q      <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
      gap_cnt_q  <= gap_cnt_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      irq_q      <= irq_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign req_ready   = (state_q == StOwn) ? grant_q : '0;
  assign grant       = grant_q;
  assign cfg_we      = we_q;
  assign cfg_addr    = addr_q;
  assign cfg_wdata   = wdata_q;
  assign cfg_irq_sel = irq_q;
  assign busy        = (state_q != StIdle);
  assign wr_count    = wr_count_q;

endmodule

// File: doc/cfg_bus_arbiter.md
Name: cfg_bus_arbiter

Overview:
Shares the dock's 8-bit config write bus (cfg_we/cfg_addr/cfg_wdata) between NUM_REQ independent masters, for example the boot-time table loader, the host config port and the debug port. The bus feeds addr_decoder window tables in the low range and irq_router route entries at IRQ_CFG_BASE and above. The block performs round-robin arbitration with burst locking, a single-cycle write strobe and a programmable inter-write gap. It sits between the masters and top's cfg_* inputs.

Parameters:
NUM_REQ, 3, number of requesting masters (2..8).
IRQ_CFG_BASE, 8'hC0, first address of the irq_router config region; must match top.
GAP_CYCLES, 1, idle cycles forced after every write strobe (0..7; 0 = no gap state).
LOCK_MAX, 16, maximum beats per grant before forced release (1..255).

Ports:
cfg_clk  in  1  config clock; all logic on rising edge.
cfg_rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-master write request.
req_addr  in  NUM_REQ*8  per-master address; master i occupies bits [8i+7:8i].
req_wdata  in  NUM_REQ*8  per-master write data; same packing as req_addr.
req_last  in  NUM_REQ  final beat of the master's burst.
req_ready  out  NUM_REQ  combinational: state==OWN and owner==i.
grant  out  NUM_REQ  registered one-hot owner; all zero when IDLE.
cfg_we  out  1  registered write strobe to the config bus.
cfg_addr  out  8  registered config address.
cfg_wdata  out  8  registered config data.
cfg_irq_sel  out  1  registered; 1 when cfg_addr >= IRQ_CFG_BASE.
busy  out  1  state != IDLE.
wr_count  out  16  saturating count of cfg_we strobes since reset.

Behaviour:
- Reset (cfg_rst=1 at a clock edge): state=IDLE; grant=0; cfg_we=0; cfg_addr=0; cfg_wdata=0; cfg_irq_sel=0; wr_count=0; rr_ptr=NUM_REQ-1, so master 0 wins first. Reset mid-burst drops any in-flight beat; cfg_we is 0 in the cycle after reset.
- FSM states: IDLE, OWN, WRITE, GAP.
- IDLE:
  - If any req_valid is set, the winner is the first requester searching upward and wrapping from rr_ptr+1.
  - Next cycle: state=OWN, grant=onehot(winner), beat_cnt=0.
  - req_ready is 0 in IDLE; there is no same-cycle grant.
- OWN:
  - req_ready[owner]=1.
  - If req_valid[owner]=1, the beat transfers: latch addr/wdata into cfg_addr/cfg_wdata and set cfg_irq_sel; record last; beat_cnt+1. Next state is WRITE.
  - If req_valid[owner]=0, release: next state IDLE, rr_ptr=owner, grant=0.
- WRITE (exactly 1 cycle): cfg_we=1 and wr_count increments, holding at 16'hFFFF.
  - Next state is GAP if GAP_CYCLES>0.
  - Otherwise, next state is determined by the release check.
- GAP: lasts GAP_CYCLES cycles with cfg_we=0 and req_ready=0. It then applies the release check.
- Release check:
  - If the beat was last, or beat_cnt==LOCK_MAX, go to IDLE with rr_ptr=owner and grant=0.
  - Otherwise return to OWN.
- Latency, GAP_CYCLES=1, valid first seen in IDLE at cycle 0:
  - cycle 1: OWN, ready high, handshake.
  - cycle 2: cfg_we high.
  - cycle 3: GAP.
  - cycle 4: OWN for the next beat, or IDLE.
  - Sustained single-master throughput is 1 write per 2+GAP_CYCLES cycles.
- cfg_addr, cfg_wdata and cfg_irq_sel hold their value after WRITE until the next transfer.
- Non-owners see req_ready=0 and must hold valid/addr/data stable until ready, which is standard valid/ready.
- LOCK_MAX forced release: the owner loses the bus even if more beats are pending. It re-competes from IDLE with the lowest priority.
- A single-requester system re-grants via IDLE after every release, costing 1 extra cycle.
- cfg_irq_sel is a comparison only. The block never blocks or rewrites any address.

Test Plan:
- Reset, then master 0 writes addr 8'h00 / data 8'h10 with last=1 -> cfg_we high for exactly one cycle, 2 cycles after valid; cfg_addr=8'h00, cfg_wdata=8'h10, cfg_irq_sel=0, wr_count=1, then IDLE with grant=0.
- Masters 0, 1 and 2 all valid with single-beat last writes, repeated 6 times -> grant order 0,1,2,0,1,2; each cfg_we carries the matching master's addr/data.
- Master 1 bursts 4 beats to 8'h00, 8'h04, 8'h08, 8'h0C (last on beat 4) while master 2 is valid -> 4 consecutive strobes from master 1 spaced 3 cycles apart (GAP=1), then master 2 is granted.
- LOCK_MAX=2 and master 0 sends 5 beats without last while master 1 is valid -> after 2 beats, master 1 is granted; master 0 resumes afterwards.
- Write to 8'hC2 -> cfg_irq_sel=1; a following write to 8'hBF -> cfg_irq_sel=0.
- Assert cfg_rst during WRITE of a burst -> cfg_we=0 on the next cycle; all outputs reset; master 0 is granted first after reset. Separately, force wr_count to saturate -> it stays at 16'hFFFF.
